// File: rtl/regfile_port_scheduler.sv
// Write-port arbiter and read sequencer for the 32x32 sync-read register file; reads take 2 cycles to rd_valid, data held until rd_ready, writes never stall.
// Optional macro DBG_READ_EN adds an idle-time debug read port (dbg_addr/dbg_data).
module regfile_port_scheduler #(
  parameter int N            = 32,
  parameter int address_size = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr0_req,
  input  logic [address_size-1:0] wr0_addr,
  input  logic [N-1:0]            wr0_data,
  output logic                    wr0_ack,
  input  logic                    wr1_req,
  input  logic [address_size-1:0] wr1_addr,
  input  logic [N-1:0]            wr1_data,
  output logic                    wr1_ack,
  input  logic                    rd_req,
  input  logic [address_size-1:0] rd_rs,
  input  logic [address_size-1:0] rd_rt,
  output logic                    rd_gnt,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [N-1:0]            rd_a,
  output logic [N-1:0]            rd_b,
  output logic                    Regwrite,
  output logic [address_size-1:0] rd_address,
  output logic [N-1:0]            write_data,
  output logic [address_size-1:0] rs_address,
  output logic [address_size-1:0] rt_address,
`ifdef DBG_READ_EN
  input  logic [address_size-1:0] dbg_addr,
  output logic [N-1:0]            dbg_data,
`endif
  input  logic [N-1:0]            reg_A,
  input  logic [N-1:0]            reg_B
);

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

  state_t                  r_state;
  logic                    r_ptr;
  logic [address_size-1:0] r_rs;
  logic [address_size-1:0] r_rt;
  logic                    r_fwd_a;
  logic                    r_fwd_b;
  logic [N-1:0]            r_fwd_data;

  logic                    w_g0;
  logic                    w_g1;
  logic                    w_idle;
  logic [address_size-1:0] w_wr_addr;
  logic [N-1:0]            w_wr_data;

  // r_ptr set means wr1 wins the next two-way tie
  always_comb begin
    w_g1      = wr1_req & (~wr0_req | r_ptr) & ~reset;
    w_g0      = wr0_req & ~w_g1 & ~reset;
    w_wr_addr = '0;
    w_wr_data = '0;
    if (w_g1) begin
      w_wr_addr = wr1_addr;
      w_wr_data = wr1_data;
    end else if (w_g0) begin
      w_wr_addr = wr0_addr;
      w_wr_data = wr0_data;
    end
  end

  assign wr0_ack    = w_g0;
  assign wr1_ack    = w_g1;
  assign Regwrite   = (w_g0 | w_g1) && (w_wr_addr != '0);
  assign rd_address = w_wr_addr;
  assign write_data = w_wr_data;

  assign w_idle     = (r_state == IDLE);
  assign rd_gnt     = w_idle & rd_req & ~reset;
  assign rt_address = w_idle ? rd_rt : r_rt;
`ifdef DBG_READ_EN
  assign rs_address = w_idle ? (rd_req ? rd_rs : dbg_addr) : r_rs;
`else
  assign rs_address = w_idle ? rd_rs : r_rs;
`endif

  function automatic logic [N-1:0] pick(input logic [address_size-1:0] addr,
                                        input logic fwd,
                                        input logic [N-1:0] fwd_data,
                                        input logic [N-1:0] file_data);
    if (addr == '0)
      return '0;
    else if (fwd)
      return fwd_data;
    else
      return file_data;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= 1'b0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_fwd_a    <= 1'b0;
      r_fwd_b    <= 1'b0;
      r_fwd_data <= '0;
      rd_valid   <= 1'b0;
      rd_a       <= '0;
      rd_b       <= '0;
    end else begin
      if (wr0_req && wr1_req)
        r_ptr <= w_g0;
      case (r_state)
        IDLE: begin
          if (rd_req) begin
            r_rs       <= rd_rs;
            r_rt       <= rd_rt;
            r_fwd_a    <= Regwrite && (rd_address == rd_rs);
            r_fwd_b    <= Regwrite && (rd_address == rd_rt);
            r_fwd_data <= write_data;
            r_state    <= FETCH;
          end
        end
        FETCH: begin
          rd_a     <= pick(r_rs, r_fwd_a, r_fwd_data, reg_A);
          rd_b     <= pick(r_rt, r_fwd_b, r_fwd_data, reg_B);
          rd_valid <= 1'b1;
          r_state  <= RESP;
        end
        RESP: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DBG_READ_EN
  logic                    r_dbg_pend;
  logic                    r_dbg_fwd;
  logic [address_size-1:0] r_dbg_addr;
  logic [N-1:0]            r_dbg_fwd_data;

  // Debug read rides the file's port A only on cycles the datapath leaves it unused
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dbg_pend     <= 1'b0;
      r_dbg_fwd      <= 1'b0;
      r_dbg_addr     <= '0;
      r_dbg_fwd_data <= '0;
      dbg_data       <= '0;
    end else begin
      r_dbg_pend     <= w_idle & ~rd_req;
      r_dbg_addr     <= dbg_addr;
      r_dbg_fwd      <= Regwrite && (rd_address == dbg_addr);
      r_dbg_fwd_data <= write_data;
      if (r_dbg_pend)
        dbg_data <= pick(r_dbg_addr, r_dbg_fwd, r_dbg_fwd_data, reg_A);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Directed bench for regfile_port_scheduler with a behavioural 32x32 synchronous-read register file.
module tb_regfile_port_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr0_req, wr1_req, rd_req, rd_ready;
  logic [4:0]  wr0_addr, wr1_addr, rd_rs, rd_rt;
  logic [31:0] wr0_data, wr1_data;
  logic        wr0_ack, wr1_ack, rd_gnt, rd_valid, Regwrite;
  logic [31:0] rd_a, rd_b, write_data, reg_A, reg_B;
  logic [4:0]  rd_address, rs_address, rt_address;

  logic [31:0] mem [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  regfile_port_scheduler #(.N(32), .address_size(5)) dut (
    .clk(clk), .reset(reset),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ack(wr0_ack),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ack(wr1_ack),
    .rd_req(rd_req), .rd_rs(rd_rs), .rd_rt(rd_rt), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_a(rd_a), .rd_b(rd_b),
    .Regwrite(Regwrite), .rd_address(rd_address), .write_data(write_data),
    .rs_address(rs_address), .rt_address(rt_address),
    .reg_A(reg_A), .reg_B(reg_B)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (Regwrite) mem[rd_address] <= write_data;
    reg_A <= mem[rs_address];
    reg_B <= mem[rt_address];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    wr0_req = 1'b0; wr1_req = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[0]   = 32'hBAD0_BAD0;
    reg_A    = '0; reg_B = '0;
    reset    = 1'b1;
    wr0_addr = 5'd3; wr0_data = 32'h3; wr1_addr = 5'd0; wr1_data = '0;
    rd_rs    = 5'd0; rd_rt = 5'd0; rd_ready = 1'b0;
    wr0_req  = 1'b1; wr1_req = 1'b0; rd_req = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", {31'b0, rd_valid}, 32'h0);
    chk("rst_rd_a", rd_a, 32'h0);
    chk("rst_gnt", {31'b0, rd_gnt}, 32'h0);
    chk("rst_ack0", {31'b0, wr0_ack}, 32'h0);
    chk("rst_regwrite", {31'b0, Regwrite}, 32'h0);
    drop_all();
    #1 reset = 1'b0;

    // single writer, then read it back
    tick();
    wr0_req = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEAD_BEEF;
    #1;
    chk("w0_regwrite", {31'b0, Regwrite}, 32'h1);
    chk("w0_addr", {27'b0, rd_address}, 32'd5);
    chk("w0_data", write_data, 32'hDEAD_BEEF);
    chk("w0_ack", {31'b0, wr0_ack}, 32'h1);
    chk("w0_ack1", {31'b0, wr1_ack}, 32'h0);
    tick();
    wr0_req = 1'b0; rd_req = 1'b1; rd_rs = 5'd5; rd_rt = 5'd0; rd_ready = 1'b1;
    #1;
    chk("r1_gnt", {31'b0, rd_gnt}, 32'h1);
    chk("r1_rs_addr", {27'b0, rs_address}, 32'd5);
    tick();
    rd_req = 1'b0; rd_rs = 5'd9;
    #1;
    chk("r1_fetch_valid", {31'b0, rd_valid}, 32'h0);
    chk("r1_fetch_rs_hold", {27'b0, rs_address}, 32'd5);
    tick();
    #1;
    chk("r1_valid", {31'b0, rd_valid}, 32'h1);
    chk("r1_rd_a", rd_a, 32'hDEAD_BEEF);
    chk("r1_rd_b_zero", rd_b, 32'h0);
    tick();
    #1;
    chk("r1_done", {31'b0, rd_valid}, 32'h0);

    // sustained tie alternates wr0, wr1, wr0, wr1
    wr0_req = 1'b1; wr0_addr = 5'd1; wr0_data = 32'h1111;
    wr1_req = 1'b1; wr1_addr = 5'd2; wr1_data = 32'h2222;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("tie_ack0", {31'b0, wr0_ack}, (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("tie_ack1", {31'b0, wr1_ack}, (k % 2 == 0) ? 32'h0 : 32'h1);
      chk("tie_addr", {27'b0, rd_address}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("tie_regwrite", {31'b0, Regwrite}, 32'h1);
      tick();
    end
    drop_all();

    // write and read of the same register in one cycle forwards the new value
    tick();
    wr1_req = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h1234_5678;
    rd_req = 1'b1; rd_rs = 5'd7; rd_rt = 5'd7; rd_ready = 1'b1;
    #1;
    chk("fw_gnt", {31'b0, rd_gnt}, 32'h1);
    chk("fw_ack1", {31'b0, wr1_ack}, 32'h1);
    tick();
    drop_all();
    tick();
    #1;
    chk("fw_rd_a", rd_a, 32'h1234_5678);
    chk("fw_rd_b", rd_b, 32'h1234_5678);

    // $zero is never written and always reads 0
    tick();
    wr0_req = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF;
    #1;
    chk("z_ack", {31'b0, wr0_ack}, 32'h1);
    chk("z_regwrite", {31'b0, Regwrite}, 32'h0);
    tick();
    wr0_req = 1'b0; rd_req = 1'b1; rd_rs = 5'd0; rd_rt = 5'd5;
    tick();
    rd_req = 1'b0;
    tick();
    #1;
    chk("z_rd_a", rd_a, 32'h0);
    chk("z_rd_b", rd_b, 32'hDEAD_BEEF);
    tick();

    // consumer stall: write to rs during RESP must not disturb held data
    rd_req = 1'b1; rd_rs = 5'd5; rd_rt = 5'd1; rd_ready = 1'b0;
    tick();
    rd_req = 1'b0;
    tick();
    wr0_req = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hCAFE_F00D;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("st_valid", {31'b0, rd_valid}, 32'h1);
      chk("st_rd_a", rd_a, 32'hDEAD_BEEF);
      tick();
      wr0_req = 1'b0;
    end
    rd_ready = 1'b1;
    #1;
    chk("st_rd_b", rd_b, 32'h1111);
    tick();
    rd_ready = 1'b0; rd_req = 1'b1; rd_rs = 5'd5; rd_rt = 5'd2;
    #1;
    chk("st_idle_valid", {31'b0, rd_valid}, 32'h0);
    chk("st_idle_gnt", {31'b0, rd_gnt}, 32'h1);
    tick();
    rd_req = 1'b0;
    tick();
    #1;
    chk("st2_rd_a", rd_a, 32'hCAFE_F00D);
    chk("st2_rd_b", rd_b, 32'h2222);
    rd_ready = 1'b1;
    tick();

    // reset in FETCH abandons the read and clears the tie pointer
    wr0_req = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h3;
    wr1_req = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h4;
    #1;
    chk("pre_tie_ack0", {31'b0, wr0_ack}, 32'h1);
    tick();
    drop_all();
    rd_req = 1'b1; rd_rs = 5'd5; rd_rt = 5'd5;
    tick();
    rd_req = 1'b0; rd_rs = 5'd9;
    reset = 1'b1;
    #1;
    chk("rf_valid", {31'b0, rd_valid}, 32'h0);
    chk("rf_rs_idle", {27'b0, rs_address}, 32'd9);
    tick();
    reset = 1'b0;
    #1;
    chk("rf_valid2", {31'b0, rd_valid}, 32'h0);
    tick();
    #1;
    chk("rf_valid3", {31'b0, rd_valid}, 32'h0);
    wr0_req = 1'b1; wr1_req = 1'b1;
    #1;
    chk("rf_tie_ack0", {31'b0, wr0_ack}, 32'h1);
    chk("rf_tie_ack1", {31'b0, wr1_ack}, 32'h0);
    tick();
    drop_all();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
